// File: rtl/fpnew_inorder_issue_if.sv
// fpnew_inorder_issue_if: handshake/data bundle between an issuer, the in-order issue block and its opgroup.
//  slave  : issue-block side. Inputs: flush_i, req_valid_i, req_data_i, in_ready_i, out_valid_i,
//           out_result_i, out_status_i, out_ext_i, out_tag_i, resp_ready_i.
//           Outputs: req_ready_o, in_valid_o, in_data_o, in_tag_o, flush_o, out_ready_o,
//           resp_valid_o, resp_result_o, resp_status_o, resp_ext_o, busy_o, spurious_o.
//  master : environment side, directions mirrored.
interface fpnew_inorder_issue_if #(
    parameter int unsigned Width    = 32,
    parameter int unsigned ReqWidth = 64,
    parameter int unsigned Depth    = 4
);
    localparam int unsigned TagWidth = $clog2(Depth);
    logic                flush_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [ReqWidth-1:0] req_data_i;
    logic                in_valid_o;
    logic                in_ready_i;
    logic [ReqWidth-1:0] in_data_o;
    logic [TagWidth-1:0] in_tag_o;
    logic                flush_o;
    logic                out_valid_i;
    logic                out_ready_o;
    logic [Width-1:0]    out_result_i;
    logic [4:0]          out_status_i;
    logic                out_ext_i;
    logic [TagWidth-1:0] out_tag_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    logic [Width-1:0]    resp_result_o;
    logic [4:0]          resp_status_o;
    logic                resp_ext_o;
    logic                busy_o;
    logic                spurious_o;
    modport slave (
        input  flush_i, req_valid_i, req_data_i, in_ready_i, out_valid_i, out_result_i,
               out_status_i, out_ext_i, out_tag_i, resp_ready_i,
        output req_ready_o, in_valid_o, in_data_o, in_tag_o, flush_o, out_ready_o,
               resp_valid_o, resp_result_o, resp_status_o, resp_ext_o, busy_o, spurious_o
    );
    modport master (
        output flush_i, req_valid_i, req_data_i, in_ready_i, out_valid_i, out_result_i,
               out_status_i, out_ext_i, out_tag_i, resp_ready_i,
        input  req_ready_o, in_valid_o, in_data_o, in_tag_o, flush_o, out_ready_o,
               resp_valid_o, resp_result_o, resp_status_o, resp_ext_o, busy_o, spurious_o
    );
endinterface

// File: rtl/fpnew_inorder_issue.sv
// fpnew_inorder_issue: issues tagged ops to an opgroup, collects out-of-order results in a ROB, retires in order.
//  clk_i : clock
//  rst_i : asynchronous active-high reset
//  bus   : fpnew_inorder_issue_if.slave (request, opgroup in/out, response, flush, status)
module fpnew_inorder_issue #(
    parameter int unsigned Width    = 32,
    parameter int unsigned ReqWidth = 64,
    parameter int unsigned Depth    = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    fpnew_inorder_issue_if.slave bus
);
    localparam int unsigned TagWidth = $clog2(Depth);
    logic [TagWidth-1:0] head_q, head_d, tail_q, tail_d;
    logic [TagWidth:0]   count_q, count_d;
    logic [Depth-1:0]    busy_q, busy_d, done_q, done_d, ext_q;
    logic [Width-1:0]    res_q [Depth];
    logic [4:0]          stat_q [Depth];
    logic                spur_q, spur_d, full, issue, retire, capture, hit;
    // full comes from the registered count, so a same-cycle retire cannot open a slot for issue
    assign full              = count_q == (TagWidth+1)'(Depth);
    assign bus.in_valid_o    = bus.req_valid_i & !full & !bus.flush_i & !rst_i;
    assign bus.req_ready_o   = bus.in_ready_i & !full & !bus.flush_i & !rst_i;
    assign bus.in_data_o     = bus.req_data_i;
    assign bus.in_tag_o      = tail_q;
    assign bus.flush_o       = bus.flush_i;
    assign bus.out_ready_o   = 1'b1;
    assign bus.resp_valid_o  = busy_q[head_q] & done_q[head_q];
    assign bus.resp_result_o = res_q[head_q];
    assign bus.resp_status_o = stat_q[head_q];
    assign bus.resp_ext_o    = ext_q[head_q];
    assign bus.busy_o        = count_q != '0;
    assign bus.spurious_o    = spur_q;
    assign issue             = bus.in_valid_o & bus.in_ready_i;
    assign retire            = bus.resp_valid_o & bus.resp_ready_i & !bus.flush_i;
    assign capture           = bus.out_valid_i & !bus.flush_i;
    assign hit               = busy_q[bus.out_tag_i] & !done_q[bus.out_tag_i];
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        if (capture && hit) done_d[bus.out_tag_i] = 1'b1;
        if (retire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
        end
        if (issue) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
        end
        head_d  = head_q + TagWidth'(retire);
        tail_d  = tail_q + TagWidth'(issue);
        count_d = count_q + (TagWidth+1)'(issue) - (TagWidth+1)'(retire);
        spur_d  = capture & !hit;
        if (bus.flush_i) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            ext_q   <= '0;
            spur_q  <= 1'b0;
            for (int i = 0; i < int'(Depth); i++) begin
                res_q[i]  <= '0;
                stat_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            spur_q  <= spur_d;
            if (capture && hit) begin
                res_q[bus.out_tag_i]  <= bus.out_result_i;
                stat_q[bus.out_tag_i] <= bus.out_status_i;
                ext_q[bus.out_tag_i]  <= bus.out_ext_i;
            end
        end
    end
endmodule

// File: tb/tb_fpnew_inorder_issue.sv
// tb_fpnew_inorder_issue: directed tables, hand sequences and random traffic against a queue-based ROB model.
module tb_fpnew_inorder_issue;
    localparam int unsigned W = 32, RW = 64, D = 4;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    fpnew_inorder_issue_if #(.Width(W), .ReqWidth(RW), .Depth(D)) bus();
    fpnew_inorder_issue #(.Width(W), .ReqWidth(RW), .Depth(D)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    typedef struct {int tag; bit done; logic [31:0] res; logic [4:0] st; bit ext;} ent_t;
    typedef struct {bit rv; bit ir; bit ov; int ot; bit rr; bit e_iv; bit e_rr; bit e_rv; bit e_busy; int e_tag; int e_res;} vec_t;
    ent_t q[$];
    int nt = 0;
    bit spur_m = 0;
    int errors = 0, checks = 0;
    vec_t tv[13];
    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic model_check();
        bit full, rv_e;
        full = q.size() == D;
        rv_e = q.size() > 0 && q[0].done;
        chk("in_valid", bus.in_valid_o, bus.req_valid_i & !full & !bus.flush_i);
        chk("req_ready", bus.req_ready_o, bus.in_ready_i & !full & !bus.flush_i);
        chk("in_tag", bus.in_tag_o, nt);
        chk("in_data", bus.in_data_o, bus.req_data_i);
        chk("flush_o", bus.flush_o, bus.flush_i);
        chk("out_ready", bus.out_ready_o, 1);
        chk("resp_valid", bus.resp_valid_o, rv_e);
        if (rv_e) begin
            chk("resp_result", bus.resp_result_o, q[0].res);
            chk("resp_status", bus.resp_status_o, q[0].st);
            chk("resp_ext", bus.resp_ext_o, q[0].ext);
        end
        chk("busy", bus.busy_o, q.size() != 0);
        chk("spurious", bus.spurious_o, spur_m);
    endtask
    task automatic set_idle();
        bus.req_valid_i = 0; bus.in_ready_i = 0; bus.out_valid_i = 0; bus.out_tag_i = '0;
        bus.resp_ready_i = 0; bus.flush_i = 0; bus.out_result_i = '0; bus.out_status_i = '0;
        bus.out_ext_i = 0; bus.req_data_i = '0;
    endtask
    task automatic drive(bit rv, bit ir, bit ov, int ot, bit rr, bit fl, logic [31:0] r);
        bus.req_valid_i = rv; bus.in_ready_i = ir; bus.out_valid_i = ov; bus.out_tag_i = 2'(ot);
        bus.resp_ready_i = rr; bus.flush_i = fl; bus.out_result_i = r;
        bus.out_status_i = r[4:0] ^ 5'h15; bus.out_ext_i = r[5];
        bus.req_data_i = {$urandom, $urandom};
        #1 model_check();
    endtask
    task automatic tick();
        bit full, ret, iss;
        int idx;
        full = q.size() == D;
        ret = q.size() > 0 && q[0].done && bus.resp_ready_i;
        iss = bus.req_valid_i & bus.in_ready_i & !full;
        @(posedge clk);
        if (bus.flush_i) begin
            q.delete(); nt = 0; spur_m = 0;
        end else begin
            spur_m = 0;
            if (bus.out_valid_i) begin
                idx = -1;
                foreach (q[i]) if (q[i].tag == int'(bus.out_tag_i)) idx = i;
                if (idx >= 0 && !q[idx].done) begin
                    q[idx].done = 1; q[idx].res = bus.out_result_i;
                    q[idx].st = bus.out_status_i; q[idx].ext = bus.out_ext_i;
                end else spur_m = 1;
            end
            if (ret) void'(q.pop_front());
            if (iss) begin
                q.push_back('{tag: nt, done: 0, res: '0, st: '0, ext: 0});
                nt = (nt + 1) % D;
            end
        end
        #1;
    endtask
    task automatic do_reset();
        set_idle();
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        q.delete(); nt = 0; spur_m = 0;
        #1;
    endtask
    initial begin
        int ot;
        int pend[$];
        tv[0]  = '{1,1,0,0,1, 1,1,0,0,0,0};
        tv[1]  = '{1,1,0,0,1, 1,1,0,1,1,0};
        tv[2]  = '{1,1,0,0,1, 1,1,0,1,2,0};
        tv[3]  = '{1,1,0,0,1, 1,1,0,1,3,0};
        tv[4]  = '{1,1,1,3,1, 0,0,0,1,0,0};
        tv[5]  = '{0,0,1,1,1, 0,0,0,1,0,0};
        tv[6]  = '{0,0,1,2,1, 0,0,0,1,0,0};
        tv[7]  = '{0,0,1,0,1, 0,0,0,1,0,0};
        tv[8]  = '{0,0,0,0,1, 0,0,1,1,0,0};
        tv[9]  = '{0,0,0,0,1, 0,0,1,1,0,1};
        tv[10] = '{0,0,0,0,1, 0,0,1,1,0,2};
        tv[11] = '{0,0,0,0,1, 0,0,1,1,0,3};
        tv[12] = '{0,0,0,0,1, 0,0,0,0,0,0};
        set_idle();
        rst = 1;
        #12 rst = 0;
        #1;
        // reset in the middle of two outstanding ops
        do_reset();
        drive(1,1,0,0,0,0,0); tick();
        drive(1,1,0,0,0,0,0); tick();
        set_idle();
        #1 chk("pre_rst_busy", bus.busy_o, 1);
        #1 rst = 1;
        #1 chk("rst_busy", bus.busy_o, 0);
        chk("rst_resp_valid", bus.resp_valid_o, 0);
        chk("rst_in_tag", bus.in_tag_o, 0);
        bus.req_valid_i = 1; bus.in_ready_i = 1;
        #1 chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_in_valid", bus.in_valid_o, 0);
        @(posedge clk);
        #1 chk("rst_edge_busy", bus.busy_o, 0);
        rst = 0;
        q.delete(); nt = 0; spur_m = 0;
        drive(1,1,0,0,0,0,0);
        chk("post_rst_tag", bus.in_tag_o, 0);
        tick();
        // in-order passthrough: each response one cycle after its result
        do_reset();
        for (int k = 0; k < 3; k++) begin drive(1,1,0,0,1,0,0); tick(); end
        drive(0,0,1,0,1,0,32'hA000_0000); chk("pt_rv0", bus.resp_valid_o, 0); tick();
        for (int k = 1; k <= 3; k++) begin
            drive(0,0,k < 3,k,1,0,32'hA000_0000 + k);
            chk("pt_rv", bus.resp_valid_o, 1);
            chk("pt_res", bus.resp_result_o, 32'hA000_0000 + k - 1);
            tick();
        end
        drive(0,0,0,0,1,0,0); chk("pt_done", bus.busy_o, 0); tick();
        // reorder table
        do_reset();
        foreach (tv[i]) begin
            drive(tv[i].rv, tv[i].ir, tv[i].ov, tv[i].ot, tv[i].rr, 0, 32'hB000_0000 + tv[i].ot);
            chk("tv_in_valid", bus.in_valid_o, tv[i].e_iv);
            chk("tv_req_ready", bus.req_ready_o, tv[i].e_rr);
            chk("tv_in_tag", bus.in_tag_o, tv[i].e_tag);
            chk("tv_resp_valid", bus.resp_valid_o, tv[i].e_rv);
            chk("tv_busy", bus.busy_o, tv[i].e_busy);
            if (tv[i].e_rv) chk("tv_resp_result", bus.resp_result_o, 32'hB000_0000 + tv[i].e_res);
            tick();
        end
        // full and wrap
        do_reset();
        for (int k = 0; k < 4; k++) begin drive(1,1,0,0,0,0,0); tick(); end
        drive(1,1,1,0,0,0,32'hC0); chk("full_req_ready", bus.req_ready_o, 0); tick();
        drive(1,1,0,0,1,0,0);
        chk("full_retire_rv", bus.resp_valid_o, 1);
        chk("full_retire_block", bus.req_ready_o, 0);
        tick();
        drive(1,1,0,0,0,0,0); chk("wrap_ready", bus.req_ready_o, 1); chk("wrap_tag", bus.in_tag_o, 0); tick();
        for (int k = 0; k < 6; k++) begin
            drive(0,0,1,(1 + k) % 4,0,0,32'hC1 + k); tick();
            drive(0,0,0,0,1,0,0); tick();
            drive(1,1,0,0,0,0,0); chk("wrap_seq_tag", bus.in_tag_o, (1 + k) % 4); tick();
        end
        // flush with a colliding result
        do_reset();
        for (int k = 0; k < 3; k++) begin drive(1,1,0,0,0,0,0); tick(); end
        drive(0,0,1,1,0,0,32'hD1); tick();
        drive(0,0,1,2,0,0,32'hD2); tick();
        drive(1,1,1,0,1,1,32'hD0);
        chk("fl_flush_o", bus.flush_o, 1);
        chk("fl_in_valid", bus.in_valid_o, 0);
        tick();
        drive(0,0,0,0,1,0,0);
        chk("fl_busy", bus.busy_o, 0); chk("fl_rv", bus.resp_valid_o, 0); chk("fl_spur", bus.spurious_o, 0);
        tick();
        drive(1,1,0,0,1,0,0); chk("fl_tag", bus.in_tag_o, 0); tick();
        drive(0,0,0,0,1,0,0); chk("fl_rv_after", bus.resp_valid_o, 0);
        // spurious: free entry, then already-done entry
        drive(0,0,1,2,0,0,32'hE2); tick();
        drive(0,0,0,0,0,0,0);
        chk("sp_pulse", bus.spurious_o, 1); chk("sp_busy", bus.busy_o, 1); chk("sp_tag", bus.in_tag_o, 1);
        tick();
        drive(0,0,1,0,0,0,32'hE0); chk("sp_clear", bus.spurious_o, 0); tick();
        drive(0,0,1,0,0,0,32'hEF); chk("sp_rv", bus.resp_valid_o, 1); tick();
        drive(0,0,0,0,0,0,0);
        chk("sp_done_pulse", bus.spurious_o, 1); chk("sp_keep", bus.resp_result_o, 32'hE0);
        tick();
        // random traffic
        do_reset();
        for (int c = 0; c < 500; c++) begin
            ot = $urandom_range(0, D - 1);
            pend.delete();
            foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0) ot = pend[$urandom_range(0, pend.size() - 1)];
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, ot,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
